// File: rtl/modring_pkg.sv
// Shared ModRing definitions: default widths, add/sub opcode and a lane slicing helper.
package modring_pkg;

  localparam int K_DEF     = 54;
  localparam int LANES_DEF = 4;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} modop_e;

  function automatic logic [K_DEF-1:0] lane(input logic [LANES_DEF*K_DEF-1:0] vec,
                                            input int i);
    return vec[i*K_DEF +: K_DEF];
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub pipeline: stage-1 raw sum/difference, stage-2 correction.
// The subtract datapath exists only when MOD_ADDSUB_LANES_SUB_EN is defined.
module mod_addsub_lane
  import modring_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en1,
  input  logic         en2,
  input  modop_e       op_in,
  input  modop_e       op_s1,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] q,
  output logic [K-1:0] res
);

  logic [K:0]   raw;
  logic [K:0]   raw_d;
  logic [K:0]   diff_q;
  logic [K-1:0] res_d;

`ifdef MOD_ADDSUB_LANES_SUB_EN
  always_comb begin
    raw_d = {1'b0, a} + {1'b0, b};
    // For subtraction bit K of raw carries the borrow into stage 2.
    if (op_in == OP_SUB) raw_d = {1'b0, a} - {1'b0, b};
  end
`else
  logic unused_op;
  assign unused_op = (op_in == OP_SUB) ^ (op_s1 == OP_SUB);

  always_comb begin
    raw_d = {1'b0, a} + {1'b0, b};
  end
`endif

  always_comb begin
    diff_q = raw - {1'b0, q};
    res_d  = diff_q[K] ? raw[K-1:0] : diff_q[K-1:0];
`ifdef MOD_ADDSUB_LANES_SUB_EN
    if (op_s1 == OP_SUB) res_d = raw[K] ? raw[K-1:0] + q : raw[K-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw <= '0;
      res <= '0;
    end else begin
      if (en1) raw <= raw_d;
      if (en2) res <= res_d;
    end
  end

endmodule

// File: rtl/mod_addsub_lanes.sv
// Multi-lane two-stage modular adder/subtractor over Z_q with valid/ready flow control.
// Define MOD_ADDSUB_LANES_SUB_EN to honour in_sub; otherwise every beat is an add.
module mod_addsub_lanes
  import modring_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int LANES = LANES_DEF,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [K-1:0]       q_in,
  input  logic               q_load,
  output logic               q_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sub,
  input  logic [LANES*K-1:0] in_a,
  input  logic [LANES*K-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*K-1:0] out_res,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic             s1_v;
  logic             s2_v;
  modop_e           s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [K-1:0]     q_reg;
  logic             s1_adv;
  logic             accept;
  logic             s2_load;
  modop_e           op_in;

`ifdef MOD_ADDSUB_LANES_SUB_EN
  assign op_in = in_sub ? OP_SUB : OP_ADD;
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign op_in      = OP_ADD;
`endif

  assign s1_adv    = !s2_v || out_ready;
  assign in_ready  = !s1_v || s1_adv;
  assign accept    = in_valid && in_ready;
  assign s2_load   = s1_adv && s1_v;
  assign out_valid = s2_v;
  assign busy      = s1_v || s2_v;

  // Stages advance only when the one downstream can take the beat; a stall freezes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_op   <= OP_ADD;
      s1_tag  <= '0;
      out_tag <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (s1_adv)   s2_v <= s1_v;
      if (accept) begin
        s1_op  <= op_in;
        s1_tag <= in_tag;
      end
      if (s2_load) out_tag <= s1_tag;
    end
  end

  // Reloads are only legal when nothing is in flight or arriving, so beats never see q change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      q_err <= 1'b0;
    end else if (q_load) begin
      if (busy || in_valid) q_err <= 1'b1;
      else                  q_reg <= q_in;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(.K(K)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en1   (accept),
      .en2   (s2_load),
      .op_in (op_in),
      .op_s1 (s1_op),
      .a     (in_a[g*K +: K]),
      .b     (in_b[g*K +: K]),
      .q     (q_reg),
      .res   (out_res[g*K +: K])
    );
  end

endmodule

// File: tb/tb_mod_addsub_lanes.sv
// Self-checking bench for mod_addsub_lanes against a plain-arithmetic modular reference model.
module tb_mod_addsub_lanes;
  import modring_pkg::*;

  localparam int K     = K_DEF;
  localparam int LANES = LANES_DEF;
  localparam int TAG_W = 4;
  localparam int VW    = LANES * K;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [K-1:0]     q_in = '0;
  logic             q_load = 1'b0;
  logic             q_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sub = 1'b0;
  logic [VW-1:0]    in_a = '0;
  logic [VW-1:0]    in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VW-1:0]    out_res;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int failures = 0;

  mod_addsub_lanes #(.K(K), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_load(q_load), .q_err(q_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: true modular add/sub for in-range operands; subtract only exists in the SUB build.
  function automatic logic [K-1:0] ref_lane(input logic [K-1:0] a, input logic [K-1:0] b,
                                            input logic sub, input logic [K-1:0] q);
    logic [K:0] s;
    logic       do_sub;
`ifdef MOD_ADDSUB_LANES_SUB_EN
    do_sub = sub;
`else
    do_sub = 1'b0 & sub;
`endif
    if (do_sub) begin
      if (a >= b) return a - b;
      return a + q - b;
    end
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[K-1:0];
  endfunction

  function automatic logic [VW-1:0] ref_beat(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                             input logic sub, input logic [K-1:0] q);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*K +: K] = ref_lane(lane(a, i), lane(b, i), sub, q);
    return r;
  endfunction

  function automatic logic [K-1:0] rand_below(input logic [K-1:0] q);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r % {{(64-K){1'b0}}, q};
    return r[K-1:0];
  endfunction

  function automatic logic [VW-1:0] rand_vec(input logic [K-1:0] q);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*K +: K] = rand_below(q);
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [K-1:0] x);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*K +: K] = x;
    return v;
  endfunction

  task automatic load_q(input logic [K-1:0] qv);
    @(posedge clk); #1;
    q_in = qv; q_load = 1'b1;
    @(posedge clk); #1;
    q_load = 1'b0;
  endtask

  // Sends one beat with out_ready held high and returns the result plus observed latency.
  task automatic run_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sub,
                          input logic [TAG_W-1:0] tag, output logic [VW-1:0] res,
                          output logic [TAG_W-1:0] rtag, output int lat);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    res = out_res; rtag = out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (q_err !== 1'b0)     begin failures++; $display("[TB] FAIL reset_q_err got %b want 0", q_err); end
    if (out_res !== '0)     begin failures++; $display("[TB] FAIL reset_out_res got %h want 0", out_res); end
    if (out_tag !== '0)     begin failures++; $display("[TB] FAIL reset_out_tag got %h want 0", out_tag); end
    if (in_ready !== 1'b1)  begin failures++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_smoke();
    logic [VW-1:0] a, b, res, exp;
    logic [TAG_W-1:0] rtag;
    int lat;
    load_q(K'(97));
    a = rand_vec(K'(97)); b = rand_vec(K'(97));
    a[K-1:0] = K'(60); b[K-1:0] = K'(50);
    exp = ref_beat(a, b, 1'b0, K'(97));
    run_beat(a, b, 1'b0, 4'd3, res, rtag, lat);
    checks += 4;
    if (res[K-1:0] !== K'(13)) begin failures++; $display("[TB] FAIL smoke_13 got %0d want 13", res[K-1:0]); end
    if (res !== exp)   begin failures++; $display("[TB] FAIL smoke_lanes got %h want %h", res, exp); end
    if (rtag !== 4'd3) begin failures++; $display("[TB] FAIL smoke_tag got %0d want 3", rtag); end
    if (lat !== 2)     begin failures++; $display("[TB] FAIL smoke_latency got %0d want 2", lat); end
    run_beat('0, '0, 1'b0, 4'd9, res, rtag, lat);
    checks += 2;
    if (res !== '0)    begin failures++; $display("[TB] FAIL smoke_zero got %h want 0", res); end
    if (rtag !== 4'd9) begin failures++; $display("[TB] FAIL smoke_zero_tag got %0d want 9", rtag); end
  endtask

  task automatic test_sub();
    logic [K-1:0] av [3] = '{K'(10), K'(20), K'(96)};
    logic [K-1:0] bv [3] = '{K'(20), K'(10), K'(96)};
    logic [VW-1:0] res, exp;
    logic [TAG_W-1:0] rtag;
    logic [K-1:0] want0;
    int lat;
    for (int i = 0; i < 3; i++) begin
      exp = ref_beat(splat(av[i]), splat(bv[i]), 1'b1, K'(97));
      run_beat(splat(av[i]), splat(bv[i]), 1'b1, TAG_W'(i + 4), res, rtag, lat);
      checks += 2;
      if (res !== exp) begin failures++; $display("[TB] FAIL sub_case%0d got %h want %h", i, res, exp); end
      if (lat !== 2)   begin failures++; $display("[TB] FAIL sub_latency%0d got %0d want 2", i, lat); end
      if (i == 0) begin
`ifdef MOD_ADDSUB_LANES_SUB_EN
        want0 = K'(87);
`else
        want0 = K'(30);
`endif
        checks++;
        if (res[K-1:0] !== want0) begin failures++; $display("[TB] FAIL sub_10_20 got %0d want %0d", res[K-1:0], want0); end
      end
    end
  endtask

  task automatic test_lanes();
    logic [K-1:0] q;
    logic [VW-1:0] a, b, res, exp;
    logic [TAG_W-1:0] rtag;
    logic sub;
    int lat;
    q = {K{1'b1}} - K'(32);
    load_q(q);
    run_beat(splat(q - K'(1)), splat(q - K'(1)), 1'b0, 4'd1, res, rtag, lat);
    checks++;
    if (res !== splat(q - K'(2))) begin failures++; $display("[TB] FAIL lanes_qm1 got %h want %h", res, splat(q - K'(2))); end
    for (int n = 0; n < 6; n++) begin
      a = rand_vec(q); b = rand_vec(q); sub = 1'($urandom_range(0, 1));
      exp = ref_beat(a, b, sub, q);
      run_beat(a, b, sub, TAG_W'(n), res, rtag, lat);
      checks += 2;
      if (res !== exp) begin failures++; $display("[TB] FAIL lanes_rand%0d got %h want %h", n, res, exp); end
      if (rtag !== TAG_W'(n)) begin failures++; $display("[TB] FAIL lanes_tag%0d got %0d want %0d", n, rtag, n); end
    end
  endtask

  task automatic test_modulus();
    logic [VW-1:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    load_q(K'(97));
    @(posedge clk); #1;
    in_a = splat(K'(60)); in_b = splat(K'(50)); in_sub = 1'b0; in_tag = 4'd7; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; q_load = 1'b1; q_in = K'(50);
    @(posedge clk); #1;
    q_load = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mod_inflight_valid got %b want 1", out_valid); end
    if (out_res !== splat(K'(13))) begin failures++; $display("[TB] FAIL mod_inflight_res got %h want %h", out_res, splat(K'(13))); end
    if (q_err !== 1'b1) begin failures++; $display("[TB] FAIL mod_busy_err got %b want 1", q_err); end
    @(posedge clk); #1;
    run_beat(splat(K'(60)), splat(K'(50)), 1'b0, 4'd2, res, rtag, lat);
    checks++;
    if (res !== splat(K'(13))) begin failures++; $display("[TB] FAIL mod_q_kept got %h want %h", res, splat(K'(13))); end
    load_q(K'(101));
    run_beat(splat(K'(60)), splat(K'(50)), 1'b0, 4'd2, res, rtag, lat);
    checks++;
    if (res !== splat(K'(9))) begin failures++; $display("[TB] FAIL mod_new_q got %h want %h", res, splat(K'(9))); end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] res;
    logic [TAG_W-1:0] rtag;
    int lat;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = splat(K'(5)); in_b = splat(K'(6)); in_sub = 1'b0; in_tag = 4'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks += 2;
    if (busy !== 1'b1)      begin failures++; $display("[TB] FAIL arst_pre_busy got %b want 1", busy); end
    if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL arst_busy got %b want 0", busy); end
    if (q_err !== 1'b0)     begin failures++; $display("[TB] FAIL arst_q_err got %b want 0", q_err); end
    if (out_res !== '0)     begin failures++; $display("[TB] FAIL arst_out_res got %h want 0", out_res); end
    if (out_tag !== '0)     begin failures++; $display("[TB] FAIL arst_out_tag got %h want 0", out_tag); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    run_beat(splat(K'(60)), splat(K'(50)), 1'b0, 4'd5, res, rtag, lat);
    checks += 3;
    if (res !== ref_beat(splat(K'(60)), splat(K'(50)), 1'b0, K'(0))) begin failures++; $display("[TB] FAIL arst_q_zero got %h want %h", res, splat(K'(110))); end
    if (lat !== 2)     begin failures++; $display("[TB] FAIL arst_latency got %0d want 2", lat); end
    if (rtag !== 4'd5) begin failures++; $display("[TB] FAIL arst_tag got %0d want 5", rtag); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_no_ghost got %b want 0", out_valid); end
    load_q(K'(97));
    checks++;
    if (q_err !== 1'b0) begin failures++; $display("[TB] FAIL legal_load_err got %b want 0", q_err); end
    @(posedge clk); #1;
    in_a = splat(K'(60)); in_b = splat(K'(50)); in_tag = 4'd6; in_valid = 1'b1;
    q_load = 1'b1; q_in = K'(50);
    @(posedge clk); #1;
    in_valid = 1'b0; q_load = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    checks += 3;
    if (lat !== 2) begin failures++; $display("[TB] FAIL load_with_valid_latency got %0d want 2", lat); end
    if (out_res !== splat(K'(13))) begin failures++; $display("[TB] FAIL load_with_valid_res got %h want %h", out_res, splat(K'(13))); end
    if (q_err !== 1'b1) begin failures++; $display("[TB] FAIL load_with_valid_err got %b want 1", q_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp_res [$];
    logic [TAG_W-1:0] exp_tag [$];
    logic [K-1:0] q;
    int acc_cnt, del_cnt;
    q = {1'b1, 53'(rand_below({K{1'b1}}))};
    load_q(q);
    acc_cnt = 0; del_cnt = 0;
    @(posedge clk); #1;
    fork
      begin
        logic acc;
        logic [VW-1:0] a, b;
        logic sub;
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
          a = rand_vec(q); b = rand_vec(q); sub = 1'($urandom_range(0, 1));
          in_a = a; in_b = b; in_sub = sub; in_tag = TAG_W'(i); in_valid = 1'b1;
          acc = 1'b0;
          for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
          end
          if (acc) begin
            exp_res.push_back(ref_beat(a, b, sub, q)); exp_tag.push_back(TAG_W'(i)); acc_cnt++;
          end else begin
            failures++; $display("[TB] FAIL bp_accept_timeout beat %0d got no in_ready want accept", i);
          end
        end
        in_valid = 1'b0;
      end
      begin
        logic held = 1'b0;
        logic [VW-1:0] held_res = '0;
        logic [TAG_W-1:0] held_tag = '0;
        logic want_ready;
        for (int cyc = 0; cyc < 600 && del_cnt < 16; cyc++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          want_ready = !((acc_cnt - del_cnt) == 2 && !out_ready);
          checks++;
          if (in_ready !== want_ready) begin failures++; $display("[TB] FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, want_ready); end
          if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_res !== held_res || out_tag !== held_tag) begin
              failures++; $display("[TB] FAIL bp_hold got v=%b tag=%0d want v=1 tag=%0d", out_valid, out_tag, held_tag);
            end
          end
          held = 1'b0;
          if (out_valid && out_ready) begin
            checks++;
            if (exp_res.size() == 0) begin
              failures++; $display("[TB] FAIL bp_extra got tag %0d want no beat", out_tag);
            end else begin
              if (out_res !== exp_res[0] || out_tag !== exp_tag[0]) begin
                failures++; $display("[TB] FAIL bp_data got tag %0d res %h want tag %0d res %h", out_tag, out_res, exp_tag[0], exp_res[0]);
              end
              void'(exp_res.pop_front()); void'(exp_tag.pop_front());
            end
            del_cnt++;
          end else if (out_valid) begin
            held = 1'b1; held_res = out_res; held_tag = out_tag;
          end
        end
      end
    join
    out_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (del_cnt !== 16) begin failures++; $display("[TB] FAIL bp_count got %0d want 16", del_cnt); end
    if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained got v=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_smoke();
    test_sub();
    test_lanes();
    test_modulus();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
